// File: rtl/xor_stream_parity_checker_pkg.sv
// Shared types and constants for the XOR stream parity checker.
package parity_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_MAX_LEN = 16;
  localparam int ERR_CNT_W   = 8;

endpackage

// File: rtl/xor_stream_parity_checker.sv
// Accumulates parity over a framed serial bit stream and reports it against an expected bit.
// Optional saturating error counter enabled by defining PARITY_CHECKER_ERR_CNT_EN.
module xor_stream_parity_checker
  import parity_chk_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
`ifdef PARITY_CHECKER_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_count,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  input  logic             in_exp_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err,
  output logic             out_overlong
);

  state_t           state;
  logic             acc;
  logic [CNT_W-1:0] cnt;
  logic             acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             in_acc;
  logic             out_acc;

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  always_comb begin
    acc_nxt = acc ^ in_bit;
    cnt_nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= 1'b0;
      cnt          <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_parity   <= 1'b0;
      out_count    <= '0;
      out_err      <= 1'b0;
      out_overlong <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_acc) begin
            acc <= in_bit;
            cnt <= CNT_W'(1);
            // MAX_LEN >= 2, so a first beat can never terminate by length
            if (in_last) begin
              state        <= HOLD;
              in_ready     <= 1'b0;
              out_valid    <= 1'b1;
              out_parity   <= in_bit;
              out_count    <= CNT_W'(1);
              out_err      <= in_bit ^ in_exp_par;
              out_overlong <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_acc) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (in_last) begin
              state        <= HOLD;
              in_ready     <= 1'b0;
              out_valid    <= 1'b1;
              out_parity   <= acc_nxt;
              out_count    <= cnt_nxt;
              out_err      <= acc_nxt ^ in_exp_par;
              out_overlong <= 1'b0;
            end else if (cnt_nxt == CNT_W'(MAX_LEN)) begin
              // Length cut-off: expected parity is meaningless, flag as error
              state        <= HOLD;
              in_ready     <= 1'b0;
              out_valid    <= 1'b1;
              out_parity   <= acc_nxt;
              out_count    <= cnt_nxt;
              out_err      <= 1'b1;
              out_overlong <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_acc) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= 1'b0;
            cnt       <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARITY_CHECKER_ERR_CNT_EN
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_acc && out_err) begin
      err_count <= sat_inc(err_count);
    end
  end
`endif

endmodule

// File: tb/tb_xor_stream_parity_checker.sv
// Directed bench for xor_stream_parity_checker: frame table plus multi-cycle corner sequences.
module tb_xor_stream_parity_checker;
  import parity_chk_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_bit = 1'b0;
  logic             in_last = 1'b0;
  logic             in_exp_par = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_parity;
  logic [CNT_W-1:0] out_count;
  logic             out_err;
  logic             out_overlong;
`ifdef PARITY_CHECKER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count;
  int                   exp_errs = 0;
`endif

  int total = 0;
  int bad   = 0;

  xor_stream_parity_checker #(.MAX_LEN(MAX_LEN)) dut (
`ifdef PARITY_CHECKER_ERR_CNT_EN
    .err_count   (err_count),
`endif
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bit      (in_bit),
    .in_last     (in_last),
    .in_exp_par  (in_exp_par),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_parity  (out_parity),
    .out_count   (out_count),
    .out_err     (out_err),
    .out_overlong(out_overlong)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [19:0] bits;      // bit 0 is sent first
    int          len;
    logic        use_last;
    logic        exp_par;
    logic        e_par;
    int          e_cnt;
    logic        e_err;
    logic        e_ov;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Sends len beats back to back; leaves the bench 1ns after the final accepting edge.
  task automatic send_frame(input logic [19:0] bits, input int len, input logic use_last,
                            input logic exp_par);
    for (int i = 0; i < len; i++) begin
      in_valid   = 1'b1;
      in_bit     = bits[i];
      in_last    = use_last && (i == len - 1);
      in_exp_par = exp_par;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (!out_valid && n < 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " out_valid"}, out_valid, 1);
  endtask

  initial begin
    vecs[0] = '{"f1011_p1",  20'h0000d, 4,  1'b1, 1'b1, 1'b1, 4,  1'b0, 1'b0};
    vecs[1] = '{"f1011_p0",  20'h0000d, 4,  1'b1, 1'b0, 1'b1, 4,  1'b1, 1'b0};
    vecs[2] = '{"overlong",  20'h0ffff, 16, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b1};
    vecs[3] = '{"one_bit0",  20'h00000, 1,  1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b0};
    vecs[4] = '{"exact_max", 20'h00001, 16, 1'b1, 1'b1, 1'b1, 16, 1'b0, 1'b0};
    vecs[5] = '{"len15",     20'h07fff, 15, 1'b1, 1'b1, 1'b1, 15, 1'b0, 1'b0};
    vecs[6] = '{"f011_p1",   20'h00006, 3,  1'b1, 1'b1, 1'b0, 3,  1'b1, 1'b0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_parity", out_parity, 0);
    chk("rst out_count", out_count, 0);
    chk("rst out_err", out_err, 0);
    chk("rst out_overlong", out_overlong, 0);
`ifdef PARITY_CHECKER_ERR_CNT_EN
    chk("rst err_count", err_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Table-driven frames, results accepted immediately
    foreach (vecs[k]) begin
      send_frame(vecs[k].bits, vecs[k].len, vecs[k].use_last, vecs[k].exp_par);
      wait_out(vecs[k].name);
      chk({vecs[k].name, " in_ready"}, in_ready, 0);
      chk({vecs[k].name, " parity"}, out_parity, vecs[k].e_par);
      chk({vecs[k].name, " count"}, out_count, vecs[k].e_cnt);
      chk({vecs[k].name, " err"}, out_err, vecs[k].e_err);
      chk({vecs[k].name, " overlong"}, out_overlong, vecs[k].e_ov);
      @(posedge clk);
      #1;
      chk({vecs[k].name, " valid_drop"}, out_valid, 0);
      chk({vecs[k].name, " ready_back"}, in_ready, 1);
`ifdef PARITY_CHECKER_ERR_CNT_EN
      if (vecs[k].e_err) exp_errs++;
      chk({vecs[k].name, " err_count"}, err_count, exp_errs);
`endif
    end

    // Single-bit frame with result back-pressured for 5 cycles
    out_ready = 1'b0;
    send_frame(20'h1, 1, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold out_valid", out_valid, 1);
      chk("hold parity", out_parity, 1);
      chk("hold count", out_count, 1);
      chk("hold err", out_err, 0);
      chk("hold in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release out_valid", out_valid, 0);
    chk("release in_ready", in_ready, 1);

    // 20 beats of 1 without in_last: only 16 are taken
    begin
      int n_acc = 0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_bit    = 1'b1;
      in_last   = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (in_ready) n_acc++;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      chk("ovl accepted", n_acc, 16);
      chk("ovl out_valid", out_valid, 1);
      chk("ovl in_ready", in_ready, 0);
      chk("ovl count", out_count, 16);
      chk("ovl parity", out_parity, 0);
      chk("ovl overlong", out_overlong, 1);
      chk("ovl err", out_err, 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("ovl released", out_valid, 0);
`ifdef PARITY_CHECKER_ERR_CNT_EN
      exp_errs++;
      chk("ovl err_count", err_count, exp_errs);
`endif
    end

    // Back-to-back frames 1,1,1 then 0,0 with in_valid held high
    begin
      logic [5:0] bits = 6'b000111;
      logic       res_par[2];
      int         res_cnt[2];
      int         idx = 0;
      int         lows = 0;
      int         nres = 0;
      logic       took;
      for (int c = 0; c < 30 && !(idx == 5 && nres == 2); c++) begin
        in_valid   = (idx < 5);
        in_bit     = bits[idx];
        in_last    = (idx == 2) || (idx == 4);
        in_exp_par = 1'b1;
        @(negedge clk);
        if (out_valid && nres < 2) begin
          res_par[nres] = out_parity;
          res_cnt[nres] = out_count;
          nres++;
        end
        if (!in_ready && idx < 5) lows++;
        took = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (took) idx++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("b2b results", nres, 2);
      chk("b2b bubbles", lows, 1);
      if (nres == 2) begin
        chk("b2b par0", res_par[0], 1);
        chk("b2b cnt0", res_cnt[0], 3);
        chk("b2b par1", res_par[1], 0);
        chk("b2b cnt1", res_cnt[1], 2);
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset after 3 accepted bits
    send_frame(20'h7, 3, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst out_valid", out_valid, 0);
    chk("arst in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(20'h3, 2, 1'b1, 1'b0);
    wait_out("post_rst");
    chk("post_rst count", out_count, 2);
    chk("post_rst parity", out_parity, 0);
    chk("post_rst err", out_err, 0);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
